// File: rtl/fft_sample_loader_if.sv
// fft_sample_loader_if: sample stream, RAM write port and FFT engine handshake
interface fft_sample_loader_if #(
  parameter int WIDTH    = 20,
  parameter int IN_WIDTH = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic [IN_WIDTH-1:0]  s_data;
  logic                 wr;
  logic [7:0]           addra;
  logic [2*WIDTH-1:0]   dina;
  logic                 frame_start;
  logic                 fft_done;
  logic                 busy;
  modport master (
    output s_valid, s_data, fft_done,
    input  s_ready, wr, addra, dina, frame_start, busy
  );
  modport slave (
    input  s_valid, s_data, fft_done,
    output s_ready, wr, addra, dina, frame_start, busy
  );
endinterface

// File: rtl/fft_sample_loader.sv
// fft_sample_loader: sign-extends real samples into complex words and fills the 256-entry FFT RAM
module fft_sample_loader #(
  parameter int WIDTH    = 20,
  parameter int IN_WIDTH = 16,
  parameter int BITREV   = 1
) (
  input logic              clk,
  input logic              rst,
  fft_sample_loader_if.slave bus
);
  typedef enum logic [1:0] {FILL, FLUSH, START, WAIT} state_t;
  state_t                    state_q;
  logic [7:0]                cnt_q;
  logic [7:0]                rev;
  logic                      wr_q;
  logic                      fs_q;
  logic [7:0]                addra_q;
  logic [2*WIDTH-1:0]        dina_q;
  logic signed [IN_WIDTH-1:0] smp;
  logic                      acc;
  for (genvar i = 0; i < 8; i++) begin : g_rev
    assign rev[i] = cnt_q[7-i];
  end
  assign smp = bus.s_data;
  assign acc = bus.s_valid & bus.s_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      fs_q    <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
    end else begin
      wr_q <= 1'b0;
      fs_q <= 1'b0;
      case (state_q)
        FILL: begin
          wr_q <= acc;
          if (acc) begin
            addra_q <= (BITREV != 0) ? rev : cnt_q;
            dina_q  <= {WIDTH'(smp), {WIDTH{1'b0}}};
            cnt_q   <= cnt_q + 8'd1;
            if (cnt_q == 8'hFF) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          fs_q    <= 1'b1;
          state_q <= START;
        end
        START: state_q <= WAIT;
        WAIT:  if (bus.fft_done) state_q <= FILL;
        default: state_q <= FILL;
      endcase
    end
  end
  assign bus.s_ready     = (state_q == FILL) & ~rst;
  assign bus.busy        = state_q != FILL;
  assign bus.wr          = wr_q;
  assign bus.addra       = addra_q;
  assign bus.dina        = dina_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_fft_sample_loader.sv
// tb_fft_sample_loader: scoreboard bench driving a bit-reversed and a natural-order loader in lockstep
module tb_fft_sample_loader;
  localparam int W  = 20;
  localparam int IW = 16;
  typedef struct {logic [7:0] a; logic [2*W-1:0] d;} exp_t;
  logic          clk = 0, rst = 1, sv = 0, done = 0;
  logic [IW-1:0] sd = '0;
  int            checks = 0, errors = 0, fs_cnt = 0;
  exp_t          q1[$], q0[$];
  logic [7:0]    mc;
  logic          acc_d;
  logic [2*W-1:0] ram1 [256];
  logic [2*W-1:0] ram0 [256];
  logic [IW-1:0] seq [256];
  always #5 clk = ~clk;
  fft_sample_loader_if #(.WIDTH(W), .IN_WIDTH(IW)) b1 ();
  fft_sample_loader_if #(.WIDTH(W), .IN_WIDTH(IW)) b0 ();
  assign b1.s_valid = sv;
  assign b1.s_data = sd;
  assign b1.fft_done = done;
  assign b0.s_valid = sv;
  assign b0.s_data = sd;
  assign b0.fft_done = done;
  fft_sample_loader #(.WIDTH(W), .IN_WIDTH(IW), .BITREV(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  fft_sample_loader #(.WIDTH(W), .IN_WIDTH(IW), .BITREV(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  function automatic logic [7:0] rev8(input logic [7:0] x);
    for (int i = 0; i < 8; i++) rev8[i] = x[7-i];
  endfunction
  function automatic logic [2*W-1:0] word(input logic [IW-1:0] s);
    return {{(W-IW){s[IW-1]}}, s, {W{1'b0}}};
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q1.delete();
      q0.delete();
      mc = 0;
      acc_d = 0;
      checks++;
      if (b1.wr !== 0 || b0.wr !== 0 || b1.s_ready !== 0 || b1.frame_start !== 0 ||
          b1.addra !== 0 || b1.dina !== 0 || b1.busy !== 0 || b0.s_ready !== 0) begin
        errors++;
        $display("FAIL reset_outputs: wr=%b s_ready=%b fs=%b addra=%h dina=%h busy=%b, required all 0",
                 b1.wr, b1.s_ready, b1.frame_start, b1.addra, b1.dina, b1.busy);
      end
    end else begin
      checks++;
      if (b1.wr !== acc_d || b0.wr !== acc_d) begin
        errors++;
        $display("FAIL wr_latency: wr1=%b wr0=%b, required %b", b1.wr, b0.wr, acc_d);
      end
      if (b1.wr === 1'b1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb_bitrev_empty: write at %h with nothing expected", b1.addra);
        end else begin
          e = q1.pop_front();
          if (b1.addra !== e.a || b1.dina !== e.d) begin
            errors++;
            $display("FAIL sb_bitrev: addra=%h dina=%h, required addra=%h dina=%h", b1.addra, b1.dina, e.a, e.d);
          end
          ram1[b1.addra] = b1.dina;
        end
      end
      if (b0.wr === 1'b1) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL sb_natural_empty: write at %h with nothing expected", b0.addra);
        end else begin
          e = q0.pop_front();
          if (b0.addra !== e.a || b0.dina !== e.d) begin
            errors++;
            $display("FAIL sb_natural: addra=%h dina=%h, required addra=%h dina=%h", b0.addra, b0.dina, e.a, e.d);
          end
          ram0[b0.addra] = b0.dina;
        end
      end
      if (b1.frame_start === 1'b1) fs_cnt++;
      acc_d = sv && b1.s_ready;
      if (acc_d) begin
        q1.push_back('{rev8(mc), word(sd)});
        q0.push_back('{mc, word(sd)});
        mc++;
      end
    end
  end
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (b1.s_ready !== 1 || b1.busy !== 0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b busy=%b, required 1/0", b1.s_ready, b1.busy);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input string name);
    int bad = 0;
    int fs0 = fs_cnt;
    sv = 1;
    sd = 0;
    for (int c = 0; c < 263; c++) begin
      @(negedge clk);
      checks++;
      if (b1.s_ready !== (c < 256) || b1.wr !== (c >= 1 && c <= 256) ||
          b1.frame_start !== (c == 257) || b1.busy !== (c >= 256)) begin
        errors++;
        $display("FAIL %s_timing c=%0d: s_ready=%b wr=%b fs=%b busy=%b, required %b %b %b %b", name, c,
                 b1.s_ready, b1.wr, b1.frame_start, b1.busy, c < 256, c >= 1 && c <= 256, c == 257, c >= 256);
      end
      @(posedge clk);
      #1 sd = IW'(c + 1);
      done = (c + 1 == 10) || (c + 1 == 257);
    end
    done = 0;
    sv = 0;
    for (int i = 0; i < 256; i++) if (ram1[rev8(8'(i))] !== word(IW'(i))) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_ram_bitrev: %0d bad entries, required 0", name, bad);
    end
    checks++;
    if (fs_cnt - fs0 != 1) begin
      errors++;
      $display("FAIL %s_frame_start_count: %0d, required 1", name, fs_cnt - fs0);
    end
  endtask
  task automatic test_handshake();
    done = 1;
    @(negedge clk);
    checks++;
    if (b1.s_ready !== 0 || b1.busy !== 1) begin
      errors++;
      $display("FAIL handshake_wait: s_ready=%b busy=%b, required 0/1", b1.s_ready, b1.busy);
    end
    @(posedge clk);
    #1 done = 0;
    @(negedge clk);
    checks++;
    if (b1.s_ready !== 1 || b1.busy !== 0) begin
      errors++;
      $display("FAIL handshake_release: s_ready=%b busy=%b, required 1/0", b1.s_ready, b1.busy);
    end
  endtask
  task automatic test_sign_ext();
    @(posedge clk);
    #1 sv = 1;
    sd = 16'h8000;
    seq[0] = sd;
    @(posedge clk);
    #1 sd = 16'h7FFF;
    seq[1] = sd;
    @(negedge clk);
    checks++;
    if (b0.dina[2*W-1:W] !== 20'hF8000 || b0.dina[W-1:0] !== 0 || b0.addra !== 0 || b1.addra !== 0) begin
      errors++;
      $display("FAIL sext_neg: dina=%h addra=%h/%h, required f8000_00000 at 00", b0.dina, b0.addra, b1.addra);
    end
    @(posedge clk);
    #1 sv = 0;
    @(negedge clk);
    checks++;
    if (b0.dina[2*W-1:W] !== 20'h07FFF || b0.dina[W-1:0] !== 0 || b0.addra !== 1 || b1.addra !== 8'h80) begin
      errors++;
      $display("FAIL sext_pos: dina=%h addra=%h/%h, required 07fff_00000 at 01/80", b0.dina, b0.addra, b1.addra);
    end
  endtask
  task automatic test_gaps();
    int n = 2, t = 0, bad = 0, fs0 = fs_cnt;
    while (n < 256 && t < 5000) begin
      @(posedge clk);
      #1 sv = 1'($urandom_range(0, 1));
      sd = IW'($urandom);
      @(negedge clk);
      if (sv && b0.s_ready) begin
        seq[n] = sd;
        n++;
      end
      t++;
    end
    @(posedge clk);
    #1 sv = 0;
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL gaps_timeout: %0d accepts, required 256", n);
    end
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) if (ram0[i] !== word(seq[i])) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gaps_ram_natural: %0d bad entries, required 0", bad);
    end
    checks++;
    if (fs_cnt - fs0 != 1 || b0.busy !== 1) begin
      errors++;
      $display("FAIL gaps_frame_start: count=%0d busy=%b, required 1/1", fs_cnt - fs0, b0.busy);
    end
  endtask
  task automatic test_reset_mid();
    int fs0;
    done = 1;
    @(posedge clk);
    #1 done = 0;
    sv = 1;
    repeat (100) @(posedge clk);
    #1 rst = 1;
    sv = 1;
    fs0 = fs_cnt;
    @(negedge clk);
    checks++;
    if (b1.wr !== 0 || b1.s_ready !== 0 || b0.wr !== 0) begin
      errors++;
      $display("FAIL reset_mid: wr=%b s_ready=%b, required 0/0", b1.wr, b1.s_ready);
    end
    @(posedge clk);
    #1 rst = 0;
    run_frame("after_reset");
    checks++;
    if (fs_cnt - fs0 != 1) begin
      errors++;
      $display("FAIL reset_mid_frame_count: %0d, required 1", fs_cnt - fs0);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    run_frame("full_rate");
    test_handshake();
    test_sign_ext();
    test_gaps();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
